fx2_slave_fifo_model: RTL

Synthesizable model of the FX2LP side of the 16-bit synchronous slave-FIFO interface: EP2 OUT FIFO (host→FPGA) and EP6 IN FIFO (FPGA→host) with packet commit. Sits opposite the USB slave-FIFO master, in the loopback bench and in on-chip self-test builds. Emulates the flag, FDATA and packet behaviour the master depends on, and flags protocol violations as sticky errors.

---
 rtl/fx2_slave_fifo_model.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/fx2_slave_fifo_model.sv
// fx2_slave_fifo_model: FX2LP side of the 16-bit synchronous slave-FIFO interface.
// EP2 OUT (host -> FPGA) is read by the master through FDATA. EP6 IN (FPGA -> host)
// is written by the master and becomes visible to the host only after a packet
// commit. Protocol violations are collected as sticky error bits.
// Build option: define FX2_FLAG_LATENCY_EN to delay FLAGA/FLAGD by one extra CLKOUT edge.
module fx2_slave_fifo_model #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned PKT_WORDS = 4
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic [1:0]  FIFOADR,
  input  logic        SLRD,
  input  logic        SLWR,
  input  logic        SLOE,
  input  logic        PKTEND,
  inout  wire  [15:0] FDATA,
  output logic        FLAGA,
  output logic        FLAGD,
  input  logic        host_wr_en,
  input  logic [15:0] host_wr_data,
  output logic        host_wr_full,
  input  logic        host_rd_en,
  output logic [15:0] host_rd_data,
  output logic        host_rd_valid,
  input  logic        err_clr,
  output logic [3:0]  err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;

  localparam logic [1:0] ADR_EP2 = 2'b00;
  localparam logic [1:0] ADR_EP6 = 2'b10;

  localparam logic [1:0] ST_EMPTY_PKT = 2'b00;
  localparam logic [1:0] ST_FILLING   = 2'b01;
  localparam logic [1:0] ST_COMMIT    = 2'b10;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_C   = CW'(PKT_WORDS);

  // Storage (contents are don't-care after reset; pointers and counts define validity)
  logic [DW-1:0] ep2_mem [DEPTH];
  logic [DW-1:0] ep6_mem [DEPTH];

  // EP2 state
  logic [AW-1:0] ep2_wr_ptr_q, ep2_wr_ptr_d;
  logic [AW-1:0] ep2_rd_ptr_q, ep2_rd_ptr_d;
  logic [CW-1:0] ep2_cnt_q,    ep2_cnt_d;

  // EP6 state: committed words sit ahead of uncommitted ones in the same ring
  logic [AW-1:0] ep6_wr_ptr_q, ep6_wr_ptr_d;
  logic [AW-1:0] ep6_rd_ptr_q, ep6_rd_ptr_d;
  logic [CW-1:0] ep6_com_q,    ep6_com_d;
  logic [CW-1:0] ep6_unc_q,    ep6_unc_d;
  logic [1:0]    pkt_state_q,  pkt_state_d;

  // Output registers
  logic [3:0]    err_q,           err_d;
  logic          flaga_q,         flaga_d;
  logic          flagd_q,         flagd_d;
  logic          host_wr_full_q,  host_wr_full_d;
  logic          host_rd_valid_q, host_rd_valid_d;
  logic [DW-1:0] host_rd_data_q,  host_rd_data_d;

  // Strobe decode
  logic          ep2_sel, ep6_sel, bad_sel;
  logic          ep2_empty, ep2_full, ep6_full;
  logic          ep2_push, ep2_pop, ep6_push, ep6_pop, pktend_hit;
  logic [CW-1:0] ep6_total;
  logic [3:0]    err_set;
  logic [DW-1:0] ep6_wdata;

  // Decode strobes against the pre-edge counts and collect violations
  always_comb begin
    ep2_sel    = (FIFOADR == ADR_EP2);
    ep6_sel    = (FIFOADR == ADR_EP6);
    bad_sel    = FIFOADR[0];
    ep6_total  = ep6_com_q + ep6_unc_q;
    ep2_empty  = (ep2_cnt_q == '0);
    ep2_full   = (ep2_cnt_q == DEPTH_C);
    ep6_full   = (ep6_total == DEPTH_C);
    ep2_pop    = ep2_sel && !SLRD && !ep2_empty;
    ep2_push   = host_wr_en && !ep2_full;
    ep6_push   = ep6_sel && !SLWR && !ep6_full;
    ep6_pop    = host_rd_en && (ep6_com_q != '0);
    pktend_hit = ep6_sel && !PKTEND;
    ep6_wdata  = FDATA;
    err_set    = '0;
    err_set[0] = ep2_sel && !SLRD && ep2_empty;
    err_set[1] = ep6_sel && !SLWR && ep6_full;
    err_set[2] = !SLOE && !SLWR;
    err_set[3] = bad_sel && (!SLRD || !SLWR || !PKTEND);
  end

  // EP2 pointer and occupancy update; simultaneous push and pop leave the count unchanged
  always_comb begin
    ep2_wr_ptr_d = ep2_wr_ptr_q;
    ep2_rd_ptr_d = ep2_rd_ptr_q;
    ep2_cnt_d    = ep2_cnt_q;
    if (ep2_push) ep2_wr_ptr_d = ep2_wr_ptr_q + AW'(1);
    if (ep2_pop)  ep2_rd_ptr_d = ep2_rd_ptr_q + AW'(1);
    case ({ep2_push, ep2_pop})
      2'b10:   ep2_cnt_d = ep2_cnt_q + CW'(1);
      2'b01:   ep2_cnt_d = ep2_cnt_q - CW'(1);
      default: ep2_cnt_d = ep2_cnt_q;
    endcase
  end

  // EP6 packet FSM: COMMIT folds the uncommitted words into the host-visible count
  always_comb begin
    pkt_state_d  = pkt_state_q;
    ep6_com_d    = ep6_com_q;
    ep6_unc_d    = ep6_unc_q;
    ep6_wr_ptr_d = ep6_wr_ptr_q;
    ep6_rd_ptr_d = ep6_rd_ptr_q;
    if (ep6_push) ep6_wr_ptr_d = ep6_wr_ptr_q + AW'(1);
    if (ep6_pop)  ep6_rd_ptr_d = ep6_rd_ptr_q + AW'(1);
    if (pkt_state_q == ST_COMMIT) begin
      ep6_com_d = ep6_com_q + ep6_unc_q;
      ep6_unc_d = '0;
    end
    if (ep6_pop)  ep6_com_d = ep6_com_d - CW'(1);
    if (ep6_push) ep6_unc_d = ep6_unc_d + CW'(1);
    case (pkt_state_q)
      ST_EMPTY_PKT: begin
        // PKTEND with nothing pending is a zero-length packet: nothing to do
        if (ep6_push) begin
          pkt_state_d = ((ep6_unc_d == PKT_C) || pktend_hit) ? ST_COMMIT : ST_FILLING;
        end
      end
      ST_FILLING: begin
        if ((ep6_unc_d == PKT_C) || pktend_hit) pkt_state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // A push landing in COMMIT opens the next packet
        if (!ep6_push) begin
          pkt_state_d = ST_EMPTY_PKT;
        end else if ((ep6_unc_d == PKT_C) || pktend_hit) begin
          pkt_state_d = ST_COMMIT;
        end else begin
          pkt_state_d = ST_FILLING;
        end
      end
      default: pkt_state_d = ST_EMPTY_PKT;
    endcase
  end

  // Flags, host status and sticky errors, all derived from post-edge counts
  always_comb begin
    flaga_d         = (ep2_cnt_d == '0);
    flagd_d         = ((ep6_com_d + ep6_unc_d) != DEPTH_C);
    host_wr_full_d  = (ep2_cnt_d == DEPTH_C);
    host_rd_valid_d = (ep6_com_d != '0);
    host_rd_data_d  = ep6_mem[ep6_rd_ptr_d];
    err_d           = err_clr ? 4'b0000 : (err_q | err_set);
  end

  // Endpoint storage writes
  always_ff @(posedge CLKOUT) begin
    if (ep2_push) ep2_mem[ep2_wr_ptr_q] <= host_wr_data;
    if (ep6_push) ep6_mem[ep6_wr_ptr_q] <= ep6_wdata;
  end

  // Control state registers
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      ep2_wr_ptr_q    <= '0;
      ep2_rd_ptr_q    <= '0;
      ep2_cnt_q       <= '0;
      ep6_wr_ptr_q    <= '0;
      ep6_rd_ptr_q    <= '0;
      ep6_com_q       <= '0;
      ep6_unc_q       <= '0;
      pkt_state_q     <= ST_EMPTY_PKT;
      err_q           <= '0;
      host_wr_full_q  <= 1'b0;
      host_rd_valid_q <= 1'b0;
      host_rd_data_q  <= '0;
    end else begin
      ep2_wr_ptr_q    <= ep2_wr_ptr_d;
      ep2_rd_ptr_q    <= ep2_rd_ptr_d;
      ep2_cnt_q       <= ep2_cnt_d;
      ep6_wr_ptr_q    <= ep6_wr_ptr_d;
      ep6_rd_ptr_q    <= ep6_rd_ptr_d;
      ep6_com_q       <= ep6_com_d;
      ep6_unc_q       <= ep6_unc_d;
      pkt_state_q     <= pkt_state_d;
      err_q           <= err_d;
      host_wr_full_q  <= host_wr_full_d;
      host_rd_valid_q <= host_rd_valid_d;
      host_rd_data_q  <= host_rd_data_d;
    end
  end

`ifdef FX2_FLAG_LATENCY_EN
  logic flaga_stage_q, flagd_stage_q;

  // Flags trail the true counts by one extra edge, like the real FX2LP
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      flaga_stage_q <= 1'b1;
      flagd_stage_q <= 1'b1;
      flaga_q       <= 1'b1;
      flagd_q       <= 1'b1;
    end else begin
      flaga_stage_q <= flaga_d;
      flagd_stage_q <= flagd_d;
      flaga_q       <= flaga_stage_q;
      flagd_q       <= flagd_stage_q;
    end
  end
`else
  // Flags track the post-edge counts directly
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      flaga_q <= 1'b1;
      flagd_q <= 1'b1;
    end else begin
      flaga_q <= flaga_d;
      flagd_q <= flagd_d;
    end
  end
`endif

  // EP2 head word onto the shared bus, zero clock latency
  assign FDATA = (!SLOE && ep2_sel) ? ep2_mem[ep2_rd_ptr_q] : {DW{1'bz}};

  assign FLAGA         = flaga_q;
  assign FLAGD         = flagd_q;
  assign host_wr_full  = host_wr_full_q;
  assign host_rd_valid = host_rd_valid_q;
  assign host_rd_data  = host_rd_data_q;
  assign err           = err_q;

endmodule
